// File: rtl/spike_pkg.sv
// spike_pkg: shared defaults and the saturating counter helper used by spike_collector and the neuron side.
package spike_pkg;
   localparam int NEURON_ID_W_DEF = 4;
   localparam int CNT_W_DEF = 8;
   // Adds inc to cnt and clamps at 2^w-1; w must be below 32.
   function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] inc, input int w);
      logic [32:0] sum;
      logic [32:0] mx;
      mx = (33'd1 << w) - 33'd1;
      sum = {1'b0, cnt} + {1'b0, inc};
      return (sum > mx) ? mx[31:0] : sum[31:0];
   endfunction
endpackage

// File: rtl/spike_collector_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant over requesting lanes; the priority pointer
// moves to the lane after the winner and holds when nothing is granted.
module rr_arbiter #(
   parameter int NUM_NEURONS = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_NEURONS-1:0] req_i,
   input  logic                   en_i,
   output logic [NUM_NEURONS-1:0] grant_o
);
   localparam int PW = $clog2(NUM_NEURONS);
   logic [PW-1:0] ptr_q, ptr_d, idx;
   int j;
   // Scan offsets from farthest to nearest so the lane closest to the pointer wins last.
   always_comb begin
      grant_o = '0;
      ptr_d = ptr_q;
      j = 0;
      idx = '0;
      if (en_i) begin
         for (int k = NUM_NEURONS - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            j = (j >= NUM_NEURONS) ? j - NUM_NEURONS : j;
            idx = PW'(j);
            if (req_i[idx]) begin
               grant_o = '0;
               grant_o[idx] = 1'b1;
               ptr_d = (idx == PW'(NUM_NEURONS - 1)) ? '0 : idx + 1'b1;
            end
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) ptr_q <= '0;
      else ptr_q <= ptr_d;
   end
endmodule

// File: rtl/spike_collector.sv
// spike_collector: per-lane pending registers, round-robin into a FWFT FIFO, per-scan counters.
// Optional SPIKE_COLLECTOR_DUP_FILTER_EN limits each lane to one accepted spike per scan.
module spike_collector
   import spike_pkg::*;
#(
   parameter int NUM_NEURONS = 4,
   parameter int NEURON_ID_W = NEURON_ID_W_DEF,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               scan_start_en,
   input  logic [NUM_NEURONS-1:0]             in_valid,
   input  logic [NUM_NEURONS*NEURON_ID_W-1:0] in_id,
   output logic [NUM_NEURONS-1:0]             in_ready,
   output logic                               out_valid,
   output logic [NEURON_ID_W-1:0]             out_id,
   input  logic                               out_ready,
   output logic [CNT_W-1:0]                   spike_count,
   output logic [CNT_W-1:0]                   drop_count,
   output logic [$clog2(FIFO_DEPTH):0]        fifo_level
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   logic [NUM_NEURONS-1:0] pend_q, pend_d, grant, acc, drp, blk;
   logic [NEURON_ID_W-1:0] pid_q [NUM_NEURONS];
   logic [NEURON_ID_W-1:0] pid_d [NUM_NEURONS];
   logic [NEURON_ID_W-1:0] mem_q [FIFO_DEPTH];
   logic [NEURON_ID_W-1:0] gid;
   logic [AW-1:0] wr_q, rd_q;
   logic [LW-1:0] lvl_q, lvl_d;
   logic [CNT_W-1:0] spike_q, spike_d, drop_q, drop_d;
   logic [31:0] ndrop;
   logic push, pop, fifo_en;
   assign pop = out_valid & out_ready;
   assign push = |grant;
   assign fifo_en = (lvl_q < LW'(FIFO_DEPTH)) | pop;
   assign in_ready = ~pend_q | grant;
   assign acc = in_valid & in_ready & ~blk;
   assign drp = in_valid & ~acc;
   assign out_valid = (lvl_q != '0);
   assign out_id = out_valid ? mem_q[rd_q] : '0;
   assign fifo_level = lvl_q;
   assign spike_count = spike_q;
   assign drop_count = drop_q;
`ifdef SPIKE_COLLECTOR_DUP_FILTER_EN
   logic [NUM_NEURONS-1:0] fired_q;
   always_ff @(posedge clk) begin
      if (!rst_n) fired_q <= '0;
      else fired_q <= scan_start_en ? '0 : (fired_q | acc);
   end
   assign blk = fired_q;
`else
   assign blk = '0;
`endif
   rr_arbiter #(.NUM_NEURONS(NUM_NEURONS)) u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req_i  (pend_q),
      .en_i   (fifo_en),
      .grant_o(grant)
   );
   // A lane granted and reloaded in the same cycle stays pending with the new ID.
   always_comb begin
      gid = '0;
      ndrop = '0;
      pend_d = (pend_q & ~grant) | acc;
      for (int i = 0; i < NUM_NEURONS; i++) begin
         pid_d[i] = acc[i] ? in_id[i*NEURON_ID_W +: NEURON_ID_W] : pid_q[i];
         gid = gid | (grant[i] ? pid_q[i] : '0);
         ndrop = ndrop + 32'(drp[i]);
      end
      lvl_d = lvl_q + LW'(push) - LW'(pop);
      spike_d = scan_start_en ? '0 : CNT_W'(sat_inc(32'(spike_q), 32'(push), CNT_W));
      drop_d = scan_start_en ? '0 : CNT_W'(sat_inc(32'(drop_q), ndrop, CNT_W));
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_q <= '0;
         wr_q <= '0;
         rd_q <= '0;
         lvl_q <= '0;
         spike_q <= '0;
         drop_q <= '0;
      end else begin
         pend_q <= pend_d;
         wr_q <= wr_q + AW'(push);
         rd_q <= rd_q + AW'(pop);
         lvl_q <= lvl_d;
         spike_q <= spike_d;
         drop_q <= drop_d;
      end
   end
   // Data storage needs no reset: validity is carried by pend_q and lvl_q.
   always_ff @(posedge clk) begin
      pid_q <= pid_d;
      if (push) mem_q[wr_q] <= gid;
   end
endmodule

// File: tb/tb_spike_collector.sv
// tb_spike_collector: randomized and directed stimulus, reference model plus scoreboard for spike_collector.
module tb_spike_collector;
   localparam int N = 4;
   localparam int W = 4;
   localparam int D = 8;
   localparam int C = 8;
   localparam int CMAX = (1 << C) - 1;
   logic clk = 1'b0;
   logic rst_n, scan_start_en, out_ready, out_valid;
   logic [N-1:0] in_valid, in_ready;
   logic [N*W-1:0] in_id;
   logic [W-1:0] out_id;
   logic [C-1:0] spike_count, drop_count;
   logic [$clog2(D):0] fifo_level;
   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mq[$];
   bit mpend[N];
   bit mfired[N];
   logic [W-1:0] mpid[N];
   int mptr, mspike, mdrop;

   always #5 clk = ~clk;

   spike_collector dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .scan_start_en(scan_start_en),
      .in_valid     (in_valid),
      .in_id        (in_id),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_id       (out_id),
      .out_ready    (out_ready),
      .spike_count  (spike_count),
      .drop_count   (drop_count),
      .fifo_level   (fifo_level)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Reference model: evaluated each cycle from the rules, state advanced to the next edge.
   always @(negedge clk) begin : model
      int g, nd;
      bit pop;
      logic [N-1:0] rdy, acc;
      if (rst_n !== 1'b1) begin
         mq.delete();
         exp_q.delete();
         mptr = 0;
         mspike = 0;
         mdrop = 0;
         for (int i = 0; i < N; i++) begin
            mpend[i] = 0;
            mfired[i] = 0;
         end
      end else begin
         pop = (mq.size() != 0) && out_ready;
         g = -1;
         if (mq.size() < D || pop)
            for (int k = 0; k < N; k++)
               if (g < 0 && mpend[(mptr + k) % N]) g = (mptr + k) % N;
         nd = 0;
         for (int i = 0; i < N; i++) begin
            rdy[i] = !mpend[i] || g == i;
            acc[i] = in_valid[i] && rdy[i] && !mfired[i];
            if (in_valid[i] && !acc[i]) nd++;
         end
         chk("in_ready", in_ready, rdy);
         chk("fifo_level", fifo_level, mq.size());
         chk("out_valid", out_valid, mq.size() != 0);
         chk("spike_count", spike_count, mspike);
         chk("drop_count", drop_count, mdrop);
         if (pop) void'(mq.pop_front());
         if (g >= 0) begin
            mq.push_back(mpid[g]);
            exp_q.push_back(mpid[g]);
            mpend[g] = 0;
            mptr = (g + 1) % N;
         end
         for (int i = 0; i < N; i++)
            if (acc[i]) begin
               mpend[i] = 1;
               mpid[i] = in_id[i*W +: W];
`ifdef SPIKE_COLLECTOR_DUP_FILTER_EN
               mfired[i] = 1;
`endif
            end
         if (scan_start_en) begin
            mspike = 0;
            mdrop = 0;
            for (int i = 0; i < N; i++) mfired[i] = 0;
         end else begin
            mspike = (mspike + (g >= 0 ? 1 : 0) > CMAX) ? CMAX : mspike + (g >= 0 ? 1 : 0);
            mdrop = (mdrop + nd > CMAX) ? CMAX : mdrop + nd;
         end
      end
   end

   // Scoreboard monitor: every accepted FIFO output must match the oldest expected ID.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_id unexpected actual=%0h required=none", out_id);
         end else chk("out_id", out_id, exp_q.pop_front());
      end
   end

   task automatic setin(input logic [N-1:0] v, input logic [N*W-1:0] id, input logic sc, input logic rdy);
      in_valid = v;
      in_id = id;
      scan_start_en = sc;
      out_ready = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] id, input logic sc, input logic rdy);
      setin(v, id, sc, rdy);
      tick();
   endtask

   task automatic idle(input logic rdy, input int n);
      repeat (n) drive('0, '0, 1'b0, rdy);
   endtask

   initial begin
      rst_n = 1'b0;
      setin('0, '0, 1'b0, 1'b0);
      tick();
      tick();
      @(negedge clk);
      chk("rst out_valid", out_valid, 0);
      chk("rst out_id", out_id, 0);
      chk("rst in_ready", in_ready, 4'hF);
      chk("rst fifo_level", fifo_level, 0);
      chk("rst counters", {spike_count, drop_count}, 0);
      #1 rst_n = 1'b1;
      tick();
      // Contention from reset: lanes 0..3 with IDs A..D emerge in lane order.
      drive(4'hF, 16'hDCBA, 1'b0, 1'b1);
      drive('0, '0, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         setin('0, '0, 1'b0, 1'b1);
         @(negedge clk);
         chk("contention out_valid", out_valid, 1);
         chk("contention order", out_id, 10 + k);
         tick();
      end
      idle(1'b1, 2);
      chk("contention drop_count", drop_count, 0);
      // Single spike, lane 2, ID 5: visible two cycles later.
      drive('0, '0, 1'b1, 1'b1);
      drive(4'b0100, 16'h0500, 1'b0, 1'b1);
      drive('0, '0, 1'b0, 1'b1);
      setin('0, '0, 1'b0, 1'b1);
      @(negedge clk);
      chk("single out_valid", out_valid, 1);
      chk("single out_id", out_id, 5);
      chk("single spike_count", spike_count, 1);
      tick();
      idle(1'b1, 3);
      // Backpressure: ten spikes on lane 0 into a stalled FIFO.
      drive('0, '0, 1'b1, 1'b0);
      for (int k = 0; k < 10; k++) drive(4'b0001, 16'(k), 1'b0, 1'b0);
      setin('0, '0, 1'b0, 1'b0);
      @(negedge clk);
      chk("bp fifo_level", fifo_level, 8);
      chk("bp drop_count", drop_count, 1);
      chk("bp spike_count", spike_count, 8);
      chk("bp in_ready0", in_ready[0], 0);
      tick();
      idle(1'b1, 12);
      chk("bp drained", fifo_level, 0);
      // Scan clear with two entries buffered.
      drive('0, '0, 1'b1, 1'b0);
      drive(4'b1000, 16'h7000, 1'b0, 1'b1);
      idle(1'b1, 3);
      drive(4'b0011, 16'h0021, 1'b0, 1'b0);
      idle(1'b0, 3);
      setin('0, '0, 1'b1, 1'b0);
      @(negedge clk);
      chk("scan pre spike_count", spike_count, 3);
      chk("scan pre fifo_level", fifo_level, 2);
      tick();
      setin('0, '0, 1'b0, 1'b0);
      @(negedge clk);
      chk("scan post spike_count", spike_count, 0);
      chk("scan post drop_count", drop_count, 0);
      chk("scan post fifo_level", fifo_level, 2);
      tick();
      idle(1'b1, 4);
      chk("scan drained", fifo_level, 0);
`ifdef SPIKE_COLLECTOR_DUP_FILTER_EN
      drive('0, '0, 1'b1, 1'b1);
      drive(4'b0010, 16'h0030, 1'b0, 1'b1);
      idle(1'b1, 2);
      drive(4'b0010, 16'h0040, 1'b0, 1'b1);
      idle(1'b1, 3);
      chk("dup spike_count", spike_count, 1);
      chk("dup drop_count", drop_count, 1);
      drive('0, '0, 1'b1, 1'b1);
      drive(4'b0010, 16'h0050, 1'b0, 1'b1);
      idle(1'b1, 3);
      chk("dup rescan spike_count", spike_count, 1);
`endif
      // Randomized traffic.
      for (int k = 0; k < 400; k++)
         drive(4'($urandom_range(0, 15) & $urandom_range(0, 15)), 16'($urandom),
               $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
      idle(1'b1, 20);
      // Reset mid-stream with five entries buffered.
      drive('0, '0, 1'b1, 1'b0);
      drive(4'hF, 16'h4321, 1'b0, 1'b0);
      idle(1'b0, 5);
      drive(4'b0001, 16'h0009, 1'b0, 1'b0);
      idle(1'b0, 3);
      setin('0, '0, 1'b0, 1'b0);
      @(negedge clk);
      chk("pre-reset fifo_level", fifo_level, 5);
      tick();
      rst_n = 1'b0;
      drive('0, '0, 1'b0, 1'b0);
      rst_n = 1'b1;
      setin('0, '0, 1'b0, 1'b0);
      @(negedge clk);
      chk("mid-reset fifo_level", fifo_level, 0);
      chk("mid-reset out_valid", out_valid, 0);
      chk("mid-reset counters", {spike_count, drop_count}, 0);
      tick();
      drive(4'b0100, 16'h0600, 1'b0, 1'b1);
      idle(1'b1, 20);
      chk("scoreboard empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
